// File: rtl/branch_resolve_unit_if.sv
// Bus between the ID stage and the branch resolver: instruction/operand inputs,
// redirect/stall outputs and branch statistics.
interface branch_resolve_unit_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             is_beq;
  logic             is_bne;
  logic             is_jump;
  logic [31:0]      pc_plus4;
  logic [31:0]      offset_sh;
  logic [25:0]      jump_index;
  logic [31:0]      rs_data;
  logic [31:0]      rt_data;
  logic             rs_pending;
  logic             rt_pending;
  logic             stall_req;
  logic             redirect;
  logic [31:0]      target;
  logic             flush_ifid;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output in_valid, is_beq, is_bne, is_jump, pc_plus4, offset_sh, jump_index,
           rs_data, rt_data, rs_pending, rt_pending,
    input  stall_req, redirect, target, flush_ifid, branch_cnt, taken_cnt
  );

  modport slave (
    input  in_valid, is_beq, is_bne, is_jump, pc_plus4, offset_sh, jump_index,
           rs_data, rt_data, rs_pending, rt_pending,
    output stall_req, redirect, target, flush_ifid, branch_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// ID-stage branch/jump resolver: compares forwarded operands, issues a registered
// one-cycle PC redirect with IF/ID flush, stalls while operands are in flight,
// and keeps saturating branch statistics.
module branch_resolve_unit #(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_resolve_unit_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_REDIR = 2'd2;

  logic [1:0]       state;
  logic             redirect_q;
  logic [31:0]      target_q;
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] taken_cnt_q;
  logic [31:0]      cap_pc;
  logic [31:0]      cap_off;
  logic             cap_beq;

  logic        is_branch;
  logic        pending;
  logic        stall;
  logic        resolve;
  logic        sel_beq;
  logic [31:0] sel_pc;
  logic [31:0] sel_off;
  logic        take;
  logic [31:0] br_target;
  logic [31:0] j_target;

  assign is_branch = bus.is_beq | bus.is_bne;
  assign pending   = bus.rs_pending | bus.rt_pending;
  assign j_target  = {bus.pc_plus4[31:28], bus.jump_index, 2'b00};

  // Stall request and branch evaluation; WAIT resolves with the captured branch, IDLE with live inputs
  always_comb begin
    stall   = 1'b0;
    resolve = 1'b0;
    sel_beq = bus.is_beq;
    sel_pc  = bus.pc_plus4;
    sel_off = bus.offset_sh;
    case (state)
      S_IDLE: begin
        stall   = bus.in_valid & ~bus.is_jump & is_branch & pending;
        resolve = bus.in_valid & ~bus.is_jump & is_branch & ~pending;
      end
      S_WAIT: begin
        stall   = pending;
        resolve = ~pending;
        sel_beq = cap_beq;
        sel_pc  = cap_pc;
        sel_off = cap_off;
      end
      default: ;
    endcase
    if (reset) begin
      stall   = 1'b0;
      resolve = 1'b0;
    end
    take      = sel_beq ? (bus.rs_data == bus.rt_data) : (bus.rs_data != bus.rt_data);
    br_target = sel_pc + sel_off;
  end

  // FSM, redirect/target registers, operand-wait capture and saturating statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      redirect_q   <= 1'b0;
      target_q     <= '0;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
      cap_pc       <= '0;
      cap_off      <= '0;
      cap_beq      <= 1'b0;
    end else begin
      redirect_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.in_valid && bus.is_jump) begin
            target_q   <= j_target;
            redirect_q <= 1'b1;
            state      <= S_REDIR;
          end else if (bus.in_valid && is_branch && pending) begin
            cap_pc  <= bus.pc_plus4;
            cap_off <= bus.offset_sh;
            cap_beq <= bus.is_beq;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!pending) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (resolve) begin
        if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + CNT_W'(1);
        if (take) begin
          if (taken_cnt_q != '1) taken_cnt_q <= taken_cnt_q + CNT_W'(1);
          target_q   <= br_target;
          redirect_q <= 1'b1;
          state      <= S_REDIR;
        end
      end
    end
  end

  assign bus.stall_req  = stall;
  assign bus.redirect   = redirect_q;
  assign bus.flush_ifid = redirect_q;
  assign bus.target     = target_q;
  assign bus.branch_cnt = branch_cnt_q;
  assign bus.taken_cnt  = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_branch_resolve_unit;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  branch_resolve_unit_if #(.CNT_W(CW)) bus ();

  branch_resolve_unit #(.CNT_W(CW)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model state
  bit          m_redir;
  bit          m_wait;
  bit          m_stall;
  logic [31:0] m_tgt;
  logic [31:0] m_cpc;
  logic [31:0] m_coff;
  bit          m_cbeq;
  int          m_b;
  int          m_t;
  logic        s_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_resolve(input bit beq, input logic [31:0] pc, input logic [31:0] off);
    bit take;
    take = beq ? (bus.rs_data == bus.rt_data) : (bus.rs_data != bus.rt_data);
    m_b = (m_b < CMAX) ? m_b + 1 : CMAX;
    if (take) begin
      m_t     = (m_t < CMAX) ? m_t + 1 : CMAX;
      m_tgt   = 32'((longint'(pc) + longint'(off)) & 64'hFFFF_FFFF);
      m_redir = 1;
    end
  endfunction

  function automatic void m_pre();
    bit pend;
    pend = bus.rs_pending | bus.rt_pending;
    if (rst || m_redir) m_stall = 0;
    else if (m_wait)    m_stall = pend;
    else                m_stall = bus.in_valid & (bus.is_beq | bus.is_bne) & pend;
  endfunction

  function automatic void m_post();
    bit pend;
    pend = bus.rs_pending | bus.rt_pending;
    if (rst) begin
      m_redir = 0; m_wait = 0; m_tgt = '0; m_b = 0; m_t = 0;
    end else if (m_redir) begin
      m_redir = 0;
    end else if (m_wait) begin
      if (!pend) begin
        m_wait = 0;
        m_resolve(m_cbeq, m_cpc, m_coff);
      end
    end else if (bus.in_valid) begin
      if (bus.is_jump) begin
        m_tgt   = (bus.pc_plus4 & 32'hF000_0000) | (32'(bus.jump_index) * 4);
        m_redir = 1;
      end else if (bus.is_beq || bus.is_bne) begin
        if (pend) begin
          m_wait = 1; m_cpc = bus.pc_plus4; m_coff = bus.offset_sh; m_cbeq = bus.is_beq;
        end else begin
          m_resolve(bus.is_beq, bus.pc_plus4, bus.offset_sh);
        end
      end
    end
  endfunction

  // typ: 0 none, 1 BEQ, 2 BNE, 3 J
  task automatic drive(input bit iv, input int typ, input logic [31:0] pc, input logic [31:0] off,
                       input logic [25:0] idx, input logic [31:0] rs, input logic [31:0] rt,
                       input bit rsp, input bit rtp);
    bus.in_valid   = iv;
    bus.is_beq     = (typ == 1);
    bus.is_bne     = (typ == 2);
    bus.is_jump    = (typ == 3);
    bus.pc_plus4   = pc;
    bus.offset_sh  = off;
    bus.jump_index = idx;
    bus.rs_data    = rs;
    bus.rt_data    = rt;
    bus.rs_pending = rsp;
    bus.rt_pending = rtp;
  endtask

  task automatic idle_in();
    drive(0, 0, 32'h0, 32'h0, 26'h0, 32'h0, 32'h0, 0, 0);
  endtask

  // one clock: check combinational stall, clock edge, check registered outputs against model
  task automatic tick();
    m_pre();
    #1;
    s_stall = bus.stall_req;
    chk("stall_req", {31'b0, bus.stall_req}, {31'b0, m_stall});
    @(posedge clk);
    m_post();
    #1;
    chk("redirect",   {31'b0, bus.redirect},   {31'b0, m_redir});
    chk("flush_ifid", {31'b0, bus.flush_ifid}, {31'b0, m_redir});
    chk("target",     bus.target,              m_tgt);
    chk("branch_cnt", 32'(bus.branch_cnt),     32'(m_b));
    chk("taken_cnt",  32'(bus.taken_cnt),      32'(m_t));
  endtask

  typedef struct {
    bit          iv;
    int          typ;
    logic [31:0] pc;
    logic [31:0] off;
    logic [25:0] idx;
    logic [31:0] rs;
    logic [31:0] rt;
    bit          e_redir;
    logic [31:0] e_tgt;
    int          e_b;
    int          e_t;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int sc;
    tests = 0; failed = 0;
    m_redir = 0; m_wait = 0; m_tgt = '0; m_b = 0; m_t = 0;
    m_cpc = '0; m_coff = '0; m_cbeq = 0;

    vecs[0] = '{1, 1, 32'h0040_0010, 32'h0000_0020, 26'h0, 32'd5, 32'd5, 1, 32'h0040_0030, 1, 1};
    vecs[1] = '{1, 2, 32'h0000_0100, 32'h0000_0040, 26'h0, 32'd7, 32'd7, 0, 32'h0040_0030, 2, 1};
    vecs[2] = '{1, 1, 32'h0000_0008, 32'hFFFF_FFF0, 26'h0, 32'd1, 32'd1, 1, 32'hFFFF_FFF8, 3, 2};
    vecs[3] = '{1, 3, 32'h9000_0004, 32'h0000_0000, 26'h0000100, 32'd0, 32'd1, 1, 32'h9000_0400, 3, 2};
    vecs[4] = '{1, 2, 32'h0000_1000, 32'hFFFF_FFFC, 26'h0, 32'd1, 32'd2, 1, 32'h0000_0FFC, 4, 3};
    vecs[5] = '{1, 1, 32'h0000_2000, 32'h0000_0010, 26'h0, 32'd3, 32'd4, 0, 32'h0000_0FFC, 5, 3};
    vecs[6] = '{1, 0, 32'h1234_5678, 32'h0000_0010, 26'h3FF, 32'd3, 32'd3, 0, 32'h0000_0FFC, 5, 3};

    // reset
    rst = 1'b1;
    idle_in();
    @(posedge clk); #1;
    tick();
    tick();
    chk("reset_target", bus.target, 32'h0);
    rst = 1'b0;

    // directed vector table, each followed by a quiet cycle
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].iv, vecs[i].typ, vecs[i].pc, vecs[i].off, vecs[i].idx,
            vecs[i].rs, vecs[i].rt, 0, 0);
      tick();
      chk("vec_stall",    {31'b0, s_stall},       32'h0);
      chk("vec_redirect", {31'b0, bus.redirect},  {31'b0, vecs[i].e_redir});
      chk("vec_target",   bus.target,             vecs[i].e_tgt);
      chk("vec_bcnt",     32'(bus.branch_cnt),    32'(vecs[i].e_b));
      chk("vec_tcnt",     32'(bus.taken_cnt),     32'(vecs[i].e_t));
      idle_in();
      tick();
      chk("vec_pulse_end", {31'b0, bus.flush_ifid}, 32'h0);
      chk("vec_hold_tgt",  bus.target,              vecs[i].e_tgt);
    end

    // operand wait: rs pending for 2 cycles, in_valid noise in WAIT/REDIR ignored
    sc = 0;
    drive(1, 1, 32'h0000_3000, 32'h0000_0100, 26'h0, 32'd1, 32'd2, 1, 0);
    tick(); sc += int'(s_stall);
    chk("wait_no_redirect", {31'b0, bus.redirect}, 32'h0);
    drive(1, 3, 32'hAAAA_0000, 32'h0000_0004, 26'h55, 32'd1, 32'd2, 1, 0);
    tick(); sc += int'(s_stall);
    chk("wait_ignore_iv", {31'b0, bus.redirect}, 32'h0);
    drive(1, 1, 32'h0000_5000, 32'h0000_0008, 26'h0, 32'd9, 32'd9, 0, 0);
    tick(); sc += int'(s_stall);
    chk("wait_stall_cycles", 32'(sc), 32'd2);
    chk("wait_redirect", {31'b0, bus.redirect}, 32'h1);
    chk("wait_target",   bus.target,            32'h0000_3100);
    drive(1, 3, 32'h7000_0000, 32'h0, 26'h5, 32'd0, 32'd0, 0, 0);
    tick();
    chk("redir_ignore_iv", {31'b0, bus.redirect}, 32'h0);
    chk("redir_hold_tgt",  bus.target,            32'h0000_3100);
    idle_in();
    tick();

    // reset while waiting drops the pending branch
    drive(1, 2, 32'h0000_4000, 32'h0000_0040, 26'h0, 32'd1, 32'd2, 0, 1);
    tick();
    rst = 1'b1;
    drive(1, 2, 32'h0000_4000, 32'h0000_0040, 26'h0, 32'd1, 32'd2, 0, 0);
    tick();
    chk("rst_wait_stall",    {31'b0, s_stall},       32'h0);
    chk("rst_wait_redirect", {31'b0, bus.redirect},  32'h0);
    chk("rst_wait_target",   bus.target,             32'h0);
    chk("rst_wait_bcnt",     32'(bus.branch_cnt),    32'h0);
    rst = 1'b0;
    idle_in();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_no_redirect", {31'b0, bus.redirect}, 32'h0);
    end

    // counter saturation
    for (int i = 0; i < CMAX + 1; i++) begin
      drive(1, 1, 32'h0000_0100, 32'h0000_0010, 26'h0, 32'd3, 32'd3, 0, 0);
      tick();
      idle_in();
      tick();
      if (i == CMAX - 2) begin
        chk("sat_pre_b", 32'(bus.branch_cnt), 32'(CMAX - 1));
        chk("sat_pre_t", 32'(bus.taken_cnt),  32'(CMAX - 1));
      end
    end
    chk("sat_bcnt", 32'(bus.branch_cnt), 32'(CMAX));
    chk("sat_tcnt", 32'(bus.taken_cnt),  32'(CMAX));
    drive(1, 2, 32'h0000_0100, 32'h0000_0010, 26'h0, 32'd3, 32'd3, 0, 0);
    tick();
    chk("sat_bcnt_nt", 32'(bus.branch_cnt), 32'(CMAX));

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = ($urandom_range(0, 1) == 1) ? a : $urandom;
      rst = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), $urandom, $urandom & 32'hFFFF_FFFC,
            26'($urandom), a, b, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      tick();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
